// File: rtl/ref_fetch_buffer_if.sv
// Load-path bundle between controller, memory port and BDUs for ref_fetch_buffer.
// master = controller/memory/BDU side, slave = the fetch buffer.
interface ref_fetch_buffer_if #(
  parameter int NUM_SLOTS = 4,
  parameter int NUM_TAGS  = 15,
  parameter int TAG_W     = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int OUT_W  = $clog2(NUM_TAGS + 1);

  logic                        req_valid;
  logic [ADDR_W-1:0]           req_addr;
  logic [SLOT_W-1:0]           req_slot;
  logic                        req_ready;
  logic [1:0]                  proc2mem_command;
  logic [ADDR_W-1:0]           proc2mem_addr;
  logic [TAG_W-1:0]            mem2proc_transaction_tag;
  logic [DATA_W-1:0]           mem2proc_data;
  logic [TAG_W-1:0]            mem2proc_data_tag;
  logic                        batch_valid;
  logic [NUM_SLOTS*DATA_W-1:0] batch_data;
  logic                        batch_ready;
  logic [OUT_W-1:0]            outstanding;
  logic                        tag_err;

  modport master (
    output req_valid, req_addr, req_slot, mem2proc_transaction_tag,
           mem2proc_data, mem2proc_data_tag, batch_ready,
    input  req_ready, proc2mem_command, proc2mem_addr, batch_valid,
           batch_data, outstanding, tag_err
  );

  modport slave (
    input  req_valid, req_addr, req_slot, mem2proc_transaction_tag,
           mem2proc_data, mem2proc_data_tag, batch_ready,
    output req_ready, proc2mem_command, proc2mem_addr, batch_valid,
           batch_data, outstanding, tag_err
  );
endinterface

// File: rtl/ref_fetch_buffer.sv
// Issues reference-block LOADs, maps memory tags to BDU slots and releases a full batch.
// Optional REF_FETCH_PERF_EN adds a saturating stall_cycles counter output.
module ref_fetch_buffer #(
  parameter int NUM_SLOTS = 4,
  parameter int NUM_TAGS  = 15,
  parameter int TAG_W     = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64
) (
  input  logic               clk,
  input  logic               rst,
  ref_fetch_buffer_if.slave  bus
`ifdef REF_FETCH_PERF_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int OUT_W  = $clog2(NUM_TAGS + 1);
  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_LOAD = 2'd1;

  typedef enum logic [1:0] {SLOT_EMPTY, SLOT_PENDING, SLOT_FULL} slot_state_t;

  logic [NUM_SLOTS-1:0]             slot_empty;
  logic [NUM_SLOTS-1:0]             slot_full_next;
  logic [NUM_TAGS-1:0]              tag_valid;
  logic [NUM_TAGS-1:0][SLOT_W-1:0]  tag_slot;
  logic [OUT_W-1:0]                 outstanding_reg;
  logic                             batch_valid_reg;
  logic                             tag_err_reg;
  logic                             issue, accept, ret_present, ret_hit, handshake;
  logic [TAG_W-1:0]                 ret_idx;
  logic [SLOT_W-1:0]                ret_slot;

  // Gating with rst keeps the memory port quiet while reset is held.
  assign issue = rst && bus.req_valid && slot_empty[bus.req_slot] && !batch_valid_reg
                 && (outstanding_reg < OUT_W'(NUM_TAGS));
  assign accept      = issue && (bus.mem2proc_transaction_tag != '0);
  assign ret_present = (bus.mem2proc_data_tag != '0);
  assign ret_idx     = bus.mem2proc_data_tag - TAG_W'(1);
  assign ret_hit     = ret_present && (ret_idx < TAG_W'(NUM_TAGS)) && tag_valid[ret_idx];
  assign ret_slot    = tag_slot[ret_idx];
  assign handshake   = batch_valid_reg && bus.batch_ready;

  assign bus.proc2mem_command = issue ? CMD_LOAD : CMD_NONE;
  assign bus.proc2mem_addr    = issue ? bus.req_addr : '0;
  assign bus.req_ready        = accept;
  assign bus.batch_valid      = batch_valid_reg;
  assign bus.outstanding      = outstanding_reg;
  assign bus.tag_err          = tag_err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      slot_state_t       state_reg, state_next;
      logic [DATA_W-1:0] data_reg;
      logic              accept_here, ret_here;

      assign accept_here = accept && (bus.req_slot == SLOT_W'(gi));
      assign ret_here    = ret_hit && (ret_slot == SLOT_W'(gi));

      always_comb begin
        state_next = state_reg;
        if (handshake)        state_next = SLOT_EMPTY;
        else if (ret_here)    state_next = SLOT_FULL;
        else if (accept_here) state_next = SLOT_PENDING;
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          state_reg <= SLOT_EMPTY;
          data_reg  <= '0;
        end else begin
          state_reg <= state_next;
          if (ret_here) data_reg <= bus.mem2proc_data;
        end
      end

      assign slot_empty[gi]     = (state_reg == SLOT_EMPTY);
      assign slot_full_next[gi] = (state_next == SLOT_FULL);
      assign bus.batch_data[gi*DATA_W +: DATA_W] = data_reg;
    end

    // A tag freed and re-granted in one cycle ends up allocated: allocate wins.
    for (gi = 0; gi < NUM_TAGS; gi++) begin : g_tag
      logic              valid_reg;
      logic [SLOT_W-1:0] slot_reg;
      logic              alloc_here, clear_here;

      assign alloc_here = accept && (bus.mem2proc_transaction_tag == TAG_W'(gi + 1));
      assign clear_here = ret_hit && (ret_idx == TAG_W'(gi));

      always_ff @(posedge clk) begin
        if (!rst) begin
          valid_reg <= 1'b0;
          slot_reg  <= '0;
        end else if (alloc_here) begin
          valid_reg <= 1'b1;
          slot_reg  <= bus.req_slot;
        end else if (clear_here) begin
          valid_reg <= 1'b0;
        end
      end

      assign tag_valid[gi] = valid_reg;
      assign tag_slot[gi]  = slot_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      outstanding_reg <= '0;
      batch_valid_reg <= 1'b0;
      tag_err_reg     <= 1'b0;
    end else begin
      if (accept && !ret_hit)      outstanding_reg <= outstanding_reg + OUT_W'(1);
      else if (!accept && ret_hit) outstanding_reg <= outstanding_reg - OUT_W'(1);
      batch_valid_reg <= &slot_full_next;
      if (ret_present && !ret_hit) tag_err_reg <= 1'b1;
    end
  end

`ifdef REF_FETCH_PERF_EN
  logic [31:0] stall_reg;
  always_ff @(posedge clk) begin
    if (!rst)                                                   stall_reg <= '0;
    else if (bus.req_valid && !accept && (stall_reg != '1))     stall_reg <= stall_reg + 32'd1;
  end
  assign stall_cycles = stall_reg;
`endif
endmodule

// File: tb/tb_ref_fetch_buffer.sv
// Directed self-checking bench for ref_fetch_buffer; one task per scenario.
module tb_ref_fetch_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ref_fetch_buffer_if #(.NUM_SLOTS(4), .NUM_TAGS(15), .TAG_W(4), .ADDR_W(32), .DATA_W(64)) bus ();

`ifdef REF_FETCH_PERF_EN
  logic [31:0] stall_cycles;
`endif

  ref_fetch_buffer #(.NUM_SLOTS(4), .NUM_TAGS(15), .TAG_W(4), .ADDR_W(32), .DATA_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef REF_FETCH_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [1:0] slot, input logic [31:0] addr, input logic [3:0] tag);
    bus.req_valid = v;
    bus.req_slot = slot;
    bus.req_addr = addr;
    bus.mem2proc_transaction_tag = tag;
  endtask

  task automatic set_ret(input logic [3:0] tag, input logic [63:0] data);
    bus.mem2proc_data_tag = tag;
    bus.mem2proc_data = data;
  endtask

  task automatic do_reset();
    set_req(1'b0, 2'd0, 32'h0, 4'd0);
    set_ret(4'd0, 64'h0);
    bus.batch_ready = 1'b0;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (bus.outstanding !== 4'd0) begin n_err++; $display("FAIL reset_outstanding got=%0d exp=0", bus.outstanding); end
    n_cmp++; if (bus.batch_valid !== 1'b0) begin n_err++; $display("FAIL reset_batch_valid got=%b exp=0", bus.batch_valid); end
    n_cmp++; if (bus.batch_data !== 256'h0) begin n_err++; $display("FAIL reset_batch_data got=%h exp=0", bus.batch_data); end
    n_cmp++; if (bus.tag_err !== 1'b0) begin n_err++; $display("FAIL reset_tag_err got=%b exp=0", bus.tag_err); end
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready got=%b exp=0", bus.req_ready); end
    n_cmp++; if (bus.proc2mem_command !== 2'd0) begin n_err++; $display("FAIL reset_command got=%0d exp=0", bus.proc2mem_command); end
    n_cmp++; if (bus.proc2mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got=%h exp=0", bus.proc2mem_addr); end
`ifdef REF_FETCH_PERF_EN
    n_cmp++; if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles); end
`endif
    $display("test_reset done");
  endtask

  task automatic test_ordered_batch();
    logic [3:0]  rtag [4] = '{4'd3, 4'd1, 4'd4, 4'd2};
    logic [63:0] rdat [4] = '{64'hA, 64'hB, 64'hC, 64'hD};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 2'(i), 32'h1000 + 32'(i * 8), 4'(i + 1));
      #1;
      n_cmp++; if (bus.proc2mem_command !== 2'd1) begin n_err++; $display("FAIL issue_cmd[%0d] got=%0d exp=1", i, bus.proc2mem_command); end
      n_cmp++; if (bus.proc2mem_addr !== 32'h1000 + 32'(i * 8)) begin n_err++; $display("FAIL issue_addr[%0d] got=%h exp=%h", i, bus.proc2mem_addr, 32'h1000 + 32'(i * 8)); end
      n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL issue_ready[%0d] got=%b exp=1", i, bus.req_ready); end
      step();
      $display("issue slot=%0d tag=%0d", i, i + 1);
    end
    set_req(1'b0, 2'd0, 32'h0, 4'd0);
    n_cmp++; if (bus.outstanding !== 4'd4) begin n_err++; $display("FAIL outstanding_4 got=%0d exp=4", bus.outstanding); end
    for (int k = 0; k < 4; k++) begin
      set_ret(rtag[k], rdat[k]);
      #1;
      n_cmp++; if (bus.batch_valid !== 1'b0) begin n_err++; $display("FAIL early_batch_valid[%0d] got=%b exp=0", k, bus.batch_valid); end
      step();
      $display("return tag=%0d data=%h", rtag[k], rdat[k]);
    end
    set_ret(4'd0, 64'h0);
    n_cmp++; if (bus.batch_valid !== 1'b1) begin n_err++; $display("FAIL batch_valid_rise got=%b exp=1", bus.batch_valid); end
    n_cmp++; if (bus.batch_data !== {64'hC, 64'hA, 64'hD, 64'hB}) begin n_err++; $display("FAIL batch_data got=%h exp=%h", bus.batch_data, {64'hC, 64'hA, 64'hD, 64'hB}); end
    n_cmp++; if (bus.outstanding !== 4'd0) begin n_err++; $display("FAIL outstanding_0 got=%0d exp=0", bus.outstanding); end
    set_req(1'b1, 2'd0, 32'h2000, 4'd6);
    #1;
    n_cmp++; if (bus.proc2mem_command !== 2'd0) begin n_err++; $display("FAIL hold_cmd got=%0d exp=0", bus.proc2mem_command); end
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready got=%b exp=0", bus.req_ready); end
    step();
    n_cmp++; if (bus.batch_data !== {64'hC, 64'hA, 64'hD, 64'hB}) begin n_err++; $display("FAIL batch_stable got=%h", bus.batch_data); end
    bus.batch_ready = 1'b1;
    step();
    bus.batch_ready = 1'b0;
    #1;
    n_cmp++; if (bus.batch_valid !== 1'b0) begin n_err++; $display("FAIL batch_ack got=%b exp=0", bus.batch_valid); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL post_ack_ready got=%b exp=1", bus.req_ready); end
    step();
    set_req(1'b0, 2'd0, 32'h0, 4'd0);
    n_cmp++; if (bus.outstanding !== 4'd1) begin n_err++; $display("FAIL post_ack_outstanding got=%0d exp=1", bus.outstanding); end
    $display("test_ordered_batch done");
  endtask

  task automatic test_reject_retry();
    do_reset();
    set_req(1'b1, 2'd1, 32'h3000, 4'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL reject_ready[%0d] got=%b exp=0", i, bus.req_ready); end
      step();
      n_cmp++; if (bus.outstanding !== 4'd0) begin n_err++; $display("FAIL reject_outstanding[%0d] got=%0d exp=0", i, bus.outstanding); end
      $display("reject cycle %0d", i);
    end
    bus.mem2proc_transaction_tag = 4'd5;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL retry_ready got=%b exp=1", bus.req_ready); end
    step();
    set_req(1'b0, 2'd0, 32'h0, 4'd0);
    n_cmp++; if (bus.outstanding !== 4'd1) begin n_err++; $display("FAIL retry_outstanding got=%0d exp=1", bus.outstanding); end
`ifdef REF_FETCH_PERF_EN
    n_cmp++; if (stall_cycles !== 32'd3) begin n_err++; $display("FAIL stall_count got=%0d exp=3", stall_cycles); end
`endif
    $display("test_reject_retry done");
  endtask

  task automatic test_tag_err();
    do_reset();
    set_ret(4'd7, 64'hFF);
    step();
    set_ret(4'd0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.tag_err !== 1'b1) begin n_err++; $display("FAIL tag_err_sticky[%0d] got=%b exp=1", i, bus.tag_err); end
      step();
    end
    n_cmp++; if (bus.batch_data !== 256'h0) begin n_err++; $display("FAIL tag_err_nowrite got=%h exp=0", bus.batch_data); end
    n_cmp++; if (bus.outstanding !== 4'd0) begin n_err++; $display("FAIL tag_err_outstanding got=%0d exp=0", bus.outstanding); end
    do_reset();
    n_cmp++; if (bus.tag_err !== 1'b0) begin n_err++; $display("FAIL tag_err_clear got=%b exp=0", bus.tag_err); end
    $display("test_tag_err done");
  endtask

  task automatic test_pending_block();
    do_reset();
    set_req(1'b1, 2'd2, 32'h4000, 4'd1);
    step();
    set_req(1'b1, 2'd2, 32'h4100, 4'd9);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (bus.proc2mem_command !== 2'd0) begin n_err++; $display("FAIL pending_cmd[%0d] got=%0d exp=0", i, bus.proc2mem_command); end
      n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL pending_ready[%0d] got=%b exp=0", i, bus.req_ready); end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, (i == 2) ? 2'd3 : 2'(i), 32'h5000, 4'(i + 2));
      step();
    end
    set_req(1'b1, 2'd2, 32'h4100, 4'd9);
    for (int t = 1; t <= 4; t++) begin
      set_ret(4'(t), 64'(t * 16'h1111));
      #1;
      n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL pending_fill_ready[%0d] got=%b exp=0", t, bus.req_ready); end
      step();
    end
    set_ret(4'd0, 64'h0);
    n_cmp++; if (bus.batch_valid !== 1'b1) begin n_err++; $display("FAIL pending_batch got=%b exp=1", bus.batch_valid); end
    n_cmp++; if (bus.batch_data[128 +: 64] !== 64'h1111) begin n_err++; $display("FAIL pending_slot2 got=%h exp=1111", bus.batch_data[128 +: 64]); end
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL pending_full_ready got=%b exp=0", bus.req_ready); end
    bus.batch_ready = 1'b1;
    step();
    bus.batch_ready = 1'b0;
    #1;
    n_cmp++; if (bus.proc2mem_command !== 2'd1) begin n_err++; $display("FAIL pending_release_cmd got=%0d exp=1", bus.proc2mem_command); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL pending_release_ready got=%b exp=1", bus.req_ready); end
    step();
    set_req(1'b0, 2'd0, 32'h0, 4'd0);
    $display("test_pending_block done");
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_req(1'b1, 2'd0, 32'h6000, 4'd3);
    step();
    set_req(1'b1, 2'd1, 32'h6008, 4'd4);
    step();
    n_cmp++; if (bus.outstanding !== 4'd2) begin n_err++; $display("FAIL same_pre_outstanding got=%0d exp=2", bus.outstanding); end
    set_req(1'b1, 2'd2, 32'h6010, 4'd3);
    set_ret(4'd3, 64'h33);
    #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL same_ready got=%b exp=1", bus.req_ready); end
    step();
    set_req(1'b0, 2'd0, 32'h0, 4'd0);
    set_ret(4'd0, 64'h0);
    n_cmp++; if (bus.outstanding !== 4'd2) begin n_err++; $display("FAIL same_outstanding got=%0d exp=2", bus.outstanding); end
    set_ret(4'd3, 64'h77);
    step();
    set_ret(4'd0, 64'h0);
    n_cmp++; if (bus.batch_data[128 +: 64] !== 64'h77) begin n_err++; $display("FAIL same_newslot got=%h exp=77", bus.batch_data[128 +: 64]); end
    n_cmp++; if (bus.batch_data[0 +: 64] !== 64'h33) begin n_err++; $display("FAIL same_oldslot got=%h exp=33", bus.batch_data[0 +: 64]); end
    n_cmp++; if (bus.outstanding !== 4'd1) begin n_err++; $display("FAIL same_post_outstanding got=%0d exp=1", bus.outstanding); end
    set_ret(4'd4, 64'h44);
    step();
    set_ret(4'd0, 64'h0);
    n_cmp++; if (bus.tag_err !== 1'b0) begin n_err++; $display("FAIL same_tag_err got=%b exp=0", bus.tag_err); end
    n_cmp++; if (bus.outstanding !== 4'd0) begin n_err++; $display("FAIL same_end_outstanding got=%0d exp=0", bus.outstanding); end
    $display("test_same_cycle done");
  endtask

  task automatic test_reset_midop();
    do_reset();
    set_req(1'b1, 2'd0, 32'h7000, 4'd1);
    step();
    set_req(1'b1, 2'd1, 32'h7008, 4'd2);
    step();
    set_req(1'b0, 2'd0, 32'h0, 4'd0);
    n_cmp++; if (bus.outstanding !== 4'd2) begin n_err++; $display("FAIL midop_pre got=%0d exp=2", bus.outstanding); end
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.outstanding !== 4'd0) begin n_err++; $display("FAIL midop_outstanding got=%0d exp=0", bus.outstanding); end
    n_cmp++; if (bus.proc2mem_command !== 2'd0) begin n_err++; $display("FAIL midop_cmd got=%0d exp=0", bus.proc2mem_command); end
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL midop_ready got=%b exp=0", bus.req_ready); end
    set_ret(4'd1, 64'h11);
    step();
    set_ret(4'd2, 64'h22);
    step();
    set_ret(4'd0, 64'h0);
    n_cmp++; if (bus.batch_data !== 256'h0) begin n_err++; $display("FAIL midop_nowrite got=%h exp=0", bus.batch_data); end
    n_cmp++; if (bus.tag_err !== 1'b1) begin n_err++; $display("FAIL midop_tag_err got=%b exp=1", bus.tag_err); end
    n_cmp++; if (bus.outstanding !== 4'd0) begin n_err++; $display("FAIL midop_post got=%0d exp=0", bus.outstanding); end
    n_cmp++; if (bus.batch_valid !== 1'b0) begin n_err++; $display("FAIL midop_batch got=%b exp=0", bus.batch_valid); end
    $display("test_reset_midop done");
  endtask

  initial begin
    test_reset();
    test_ordered_batch();
    test_reject_retry();
    test_tag_err();
    test_pending_block();
    test_same_cycle();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ref_fetch_buffer.md
Name: ref_fetch_buffer

Overview:
- Sits between the memory controller and the memory port on the load path.
- Issues LOAD requests for reference-point blocks on behalf of the controller and tracks each outstanding memory tag against the BDU slot it is destined for.
- Collects out-of-order returns into one slot per BDU and presents a complete batch of NUM_SLOTS blocks to the BDUs with a valid/ready handshake.

Parameters:
- NUM_SLOTS, 4: number of destination slots; equals `NUM_BDU.
- NUM_TAGS, 15: number of memory tags; tag 0 means "no tag".
- TAG_W, 4: tag width; must satisfy 2^TAG_W > NUM_TAGS.
- ADDR_W, 32: address width.
- DATA_W, 64: MEM_BLOCK width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- req_valid  in  1  controller requests a fetch
- req_addr  in  ADDR_W  block address to load
- req_slot  in  $clog2(NUM_SLOTS)  destination slot
- req_ready  out  1  request accepted this cycle
- proc2mem_command  out  2  NONE=0, LOAD=1, STORE=2
- proc2mem_addr  out  ADDR_W  request address
- mem2proc_transaction_tag  in  TAG_W  tag granted this cycle; 0 = rejected
- mem2proc_data  in  DATA_W  returning block
- mem2proc_data_tag  in  TAG_W  tag of the returning block; 0 = no data
- batch_valid  out  1  all slots FULL
- batch_data  out  NUM_SLOTS*DATA_W  slot i occupies bits [i*DATA_W +: DATA_W]
- batch_ready  in  1  BDUs consume the batch
- outstanding  out  $clog2(NUM_TAGS+1)  number of in-flight tags
- tag_err  out  1  sticky flag: a return carried an unmatched tag

Behaviour:
- Slot state machine, one per slot: EMPTY -> PENDING on an accepted request -> FULL on its data return -> EMPTY on batch handshake.
- Tag table: NUM_TAGS entries of {valid, slot}, indexed by tag-1.
- Issue logic (combinational):
  - If req_valid, slot[req_slot] is EMPTY, batch_valid is 0, and outstanding < NUM_TAGS, drive proc2mem_command=LOAD and proc2mem_addr=req_addr.
  - Otherwise drive command NONE and address 0.
- Accept: req_ready = issue condition AND mem2proc_transaction_tag != 0, in the same cycle.
  - On the next edge: the table entry is set valid with req_slot, the slot goes PENDING, and outstanding increments.
  - A rejected request (tag 0) changes no state; the controller holds req_valid and retries.
- Return: when mem2proc_data_tag != 0 and its entry is valid:
  - mem2proc_data is written into that slot and the slot goes FULL.
  - The entry is cleared and outstanding decrements.
  - If the entry is invalid, nothing is written and tag_err is set.
- Simultaneous accept and return in one cycle: both take effect, and outstanding is unchanged.
  - This also holds when the freed tag is re-granted in the same cycle; the return is processed first, then the allocate.
- batch_valid is registered: it goes to 1 on the edge where the last slot becomes FULL.
  - While batch_valid=1, batch_data is stable and no new requests are issued.
- Handshake: batch_valid && batch_ready at an edge sets all slots EMPTY and batch_valid=0 on that edge.
  - A request can be accepted on the following cycle.
- Reset (rst=0 at an edge), including mid-operation:
  - All slots EMPTY, all table entries invalid, outstanding=0, batch_valid=0, batch_data=0, tag_err=0.
  - Outputs read back as req_ready=0, command NONE, addr 0.
  - Returns for tags issued before reset are dropped and set tag_err.
- Latency: from the last data return to batch_valid=1 is 1 cycle.

Optional Feature:
- Macro: REF_FETCH_PERF_EN.
- With it defined, add output stall_cycles, 32 bits, reset to 0. It increments every cycle in which req_valid=1 and req_ready=0, and saturates at all ones.
- Without it, the port and counter do not exist.

Test Plan:
- Four accepted requests with tags 1,2,3,4 to slots 0..3, returns in order 3,1,4,2 with data 0xA..0xD -> batch_valid rises 1 cycle after the tag-2 return; slot0=0xB, slot1=0xD, slot2=0xA, slot3=0xC.
- req_valid with mem2proc_transaction_tag=0 for 3 cycles, then tag 5 -> req_ready=0 for 3 cycles then 1; outstanding goes 0 -> 1.
- Return of tag 7 with no outstanding entry -> no slot changes, tag_err=1 and stays 1 until reset.
- Request to a PENDING slot 2 -> command NONE and req_ready=0 until slot 2's data returns and the batch completes and is acked.
- Same-cycle return of tag 3 and accept of a new request granted tag 3 -> outstanding unchanged; the new entry is valid with the new slot.
- Reset asserted with 2 tags outstanding, then returns for those tags -> all outputs at reset values, no slot written, tag_err=1.
